// File: rtl/latency_avg.sv
// Average-latency post-processor: samples issue/aggregate counters on request and
// divides them with a one-bit-per-cycle restoring divider behind a valid/ready output.
//   state | meaning
//   IDLE  | waiting for req; operands latched on the accepting edge
//   CALC  | W restoring steps, quotient MSB first
//   DONE  | result held on avg_*_r until avg_vld_r & avg_rdy
module latency_avg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic [W-1:0] issue_cnt,
  input  logic [W-1:0] aggregate_cnt,
  output logic         busy,
  output logic         avg_vld_r,
  input  logic         avg_rdy,
  output logic [W-1:0] avg_r,
  output logic [W-1:0] avg_frac_r,
  output logic         div0_r
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           vld_d, div0_d;
  logic [W-1:0]   avg_d, frac_d;

  logic [W:0]     shifted;
  logic [W:0]     trial;
  logic           qbit;
  logic [W-1:0]   rem_next;
  logic [W-1:0]   quo_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      avg_vld_r  <= 1'b0;
      avg_r      <= '0;
      avg_frac_r <= '0;
      div0_r     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      avg_vld_r  <= vld_d;
      avg_r      <= avg_d;
      avg_frac_r <= frac_d;
      div0_r     <= div0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = (issue_cnt == '0) ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    if (avg_vld_r && avg_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The remainder stays below the divisor, so W bits plus the trial borrow bit suffice.
  assign shifted  = {rem_q, dvd_q[W-1]};
  assign trial    = shifted - {1'b0, dvs_q};
  assign qbit     = ~trial[W];
  assign rem_next = qbit ? trial[W-1:0] : shifted[W-1:0];
  assign quo_next = {dvd_q[W-2:0], qbit};

  always_comb begin
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    vld_d  = avg_vld_r;
    avg_d  = avg_r;
    frac_d = avg_frac_r;
    div0_d = div0_r;
    case (state_q)
      IDLE: begin
        if (req) begin
          dvd_d  = aggregate_cnt;
          dvs_d  = issue_cnt;
          div0_d = 1'b0;
          if (issue_cnt == '0) begin
            avg_d  = '0;
            frac_d = '0;
            div0_d = 1'b1;
            vld_d  = 1'b1;
          end else begin
            cnt_d = CW'(W - 1);
            rem_d = '0;
          end
        end
      end
      CALC: begin
        rem_d = rem_next;
        dvd_d = quo_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          avg_d  = quo_next;
          frac_d = rem_next;
          vld_d  = 1'b1;
        end
      end
      DONE: begin
        if (avg_vld_r && avg_rdy) vld_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: doc/latency_avg.md
Name: latency_avg

Overview:
- Post-processing stage downstream of the issue/latency accumulator.
- On request, samples the accumulator's issue count and aggregate latency, then computes the average latency (aggregate / issue) with an iterative restoring divider.
- Presents quotient and remainder on a valid/ready output handshake.
- Keeps the divider off the accumulator's critical path; one quotient bit per cycle.

Parameters:
W, 32, width of the input counters and of the quotient and remainder outputs (W >= 2).

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  synchronous active-high reset
req  input  1  request an average computation; sampled only in IDLE
issue_cnt  input  W  divisor: number of issued transactions
aggregate_cnt  input  W  dividend: accumulated in-flight cycles
busy  output  1  state != IDLE; combinational from the state register
avg_vld_r  output  1  result valid (registered)
avg_rdy  input  1  consumer accepts the result
avg_r  output  W  quotient: floor(aggregate_cnt / issue_cnt)
avg_frac_r  output  W  remainder: aggregate_cnt mod issue_cnt
div0_r  output  1  set with the result when the sampled issue_cnt was 0

Behaviour:
- Reset (rst=1 at an edge, overriding everything):
  - state=IDLE
  - avg_vld_r=0, avg_r=0, avg_frac_r=0, div0_r=0
  - internal iteration counter, dividend, divisor and partial-remainder registers cleared
  - busy=0 in the following cycle
  - Reset mid-CALC or in DONE abandons the operation; no result is produced.
- States: IDLE, CALC, DONE.
- IDLE, req=1 at an edge:
  - Latch dividend=aggregate_cnt and divisor=issue_cnt.
  - Clear div0_r.
  - If issue_cnt==0: go directly to DONE with avg_r=0, avg_frac_r=0, div0_r=1, avg_vld_r=1, all visible after that same edge.
  - Else: go to CALC with iteration counter=W-1 and partial remainder=0.
- IDLE, req=0: hold.
- CALC: one restoring step per edge, MSB first.
  - Shift left (remainder, dividend) by 1.
  - Trial-subtract the divisor; the partial remainder is W+1 bits to hold the borrow.
  - If the result is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
  - Exactly W edges in CALC.
  - On the edge where counter==0: state<=DONE, avg_r<=final quotient, avg_frac_r<=final remainder, avg_vld_r<=1.
- Latency: avg_vld_r visible W edges after the accepting edge (divisor nonzero), or 1 edge (divisor zero).
- DONE:
  - avg_vld_r=1; avg_r, avg_frac_r and div0_r are stable.
  - Leaves on the edge with avg_vld_r & avg_rdy: avg_vld_r<=0, state<=IDLE.
  - Otherwise holds indefinitely (backpressure).
- avg_rdy may already be high in the cycle avg_vld_r first rises; the handshake completes at the next edge.
- req outside IDLE (including the DONE handshake cycle) is ignored, not queued.
- The minimum spacing between accepted requests is therefore W+2 edges.
- After the handshake, avg_r, avg_frac_r and div0_r retain their last values until the next result is loaded; only avg_vld_r qualifies them.
- Inputs issue_cnt and aggregate_cnt are don't-care except at the accepting edge.
- Arithmetic is unsigned. The quotient always fits in W bits. A dividend of 0 yields 0 remainder 0. A dividend smaller than the divisor yields 0 with remainder equal to the dividend.

Test Plan:
1. W=32, aggregate_cnt=100, issue_cnt=7, req pulse, avg_rdy=1 -> avg_vld_r high exactly 32 edges after accept; avg_r=14, avg_frac_r=2, div0_r=0; busy drops one edge after the handshake.
2. aggregate_cnt=55, issue_cnt=0, req -> after the accepting edge avg_vld_r=1, div0_r=1, avg_r=0, avg_frac_r=0; no CALC cycles.
3. Boundary values:
   - aggregate_cnt=0xFFFF_FFFF, issue_cnt=1 -> avg_r=0xFFFF_FFFF, avg_frac_r=0.
   - aggregate_cnt=5, issue_cnt=9 -> avg_r=0, avg_frac_r=5.
   - aggregate_cnt=0xFFFF_FFFF, issue_cnt=0xFFFF_FFFF -> avg_r=1, avg_frac_r=0.
4. Backpressure: result 100/7 ready, avg_rdy=0 for 10 cycles, req pulsed with issue_cnt=3 during the hold -> avg_vld_r stays 1, outputs stay 14/2, req ignored. Then avg_rdy=1 -> avg_vld_r=0 next edge; a new req for 10/3 -> avg_r=3, avg_frac_r=1.
5. rst asserted on the 16th CALC edge of 100/7 -> next cycle state IDLE, busy=0, all outputs 0, no avg_vld_r ever seen for that request. A follow-up req for 10/3 -> 3 remainder 1 after 32 edges.
6. Random regression, 10k requests with random values including zeros and random avg_rdy stalls -> every result matches the reference model (/ and %); req-to-valid latency is always W edges or 1 edge.
